// File: rtl/rv32i_pkg.sv
// Shared RV32I sequencing definitions: FSM state encodings and major opcode constants.
package rv32i_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StErr    = 3'd6
  } seq_state_e;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;

  function automatic logic opc_is_branch(input logic [6:0] opc);
    return opc == OpcBranch;
  endfunction

  function automatic logic opc_is_known(input logic [6:0] opc);
    return opc inside {OpcLoad, OpcStore, OpcBranch, OpcOp, OpcOpImm};
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Wait-cycle counter for outstanding memory requests; expired fires on the LIMIT-th waiting cycle.
module seq_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  // Asserted combinationally so the FSM leaves on the same edge the count reaches LIMIT.
  assign expired = count_en && (cnt_q == CntW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back with timeout.
// Optional SEQ_PERF_CNT_EN adds a 32-bit retired-instruction counter on instret.
module core_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] ins,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        dm_en_in,
  input  logic        dm_rw_in,
  output logic        dm_req,
  output logic        dm_we,
  input  logic        dm_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        rf_we,
  output logic        retire,
  output logic [2:0]  state,
  output logic        err,
  output logic [31:0] instret
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        store_q, store_d;
  logic        err_q;
  logic        tmo_expired;
  logic        tmo_count_en;
  seq_state_e  after_retire;

  logic unused_tgt_lsbs;
  logic unused_opc_known;
  assign unused_tgt_lsbs  = ^branch_target[1:0];
  assign unused_opc_known = opc_is_known(ir_q[6:0]);

  assign after_retire = run ? StFetch : StIdle;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    store_d  = store_q;
    imem_req = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = ins;
          state_d = StDecode;
        end else if (tmo_expired) begin
          state_d = StErr;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (opc_is_branch(ir_q[6:0])) begin
          retire  = 1'b1;
          pc_d    = branch_taken ? {branch_target[31:2], 2'b00} : pc_q + 32'd4;
          state_d = after_retire;
        end else if (dm_en_in) begin
          store_d = dm_rw_in;
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dm_req = 1'b1;
        dm_we  = store_q;
        if (dm_ack) begin
          if (store_q) begin
            retire  = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = after_retire;
          end else begin
            state_d = StWb;
          end
        end else if (tmo_expired) begin
          state_d = StErr;
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        pc_d    = pc_q + 32'd4;
        state_d = after_retire;
      end
      StErr: state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      store_q <= store_d;
      if (state_d == StErr) err_q <= 1'b1;
    end
  end

  assign tmo_count_en = ((state_q == StFetch) && !imem_ack) || ((state_q == StMem) && !dm_ack);

  seq_timeout_ctr #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .count_en(tmo_count_en),
    .clear   (state_d != state_q),
    .expired (tmo_expired)
  );

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;
  assign err       = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-instruction expectations queued at issue, checked at retire.
module tb_core_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_MEM = 3'd4,
                         S_ERR = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ins = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        dm_en_in = 1'b0;
  logic        dm_rw_in = 1'b0;
  logic        dm_req;
  logic        dm_we;
  logic        dm_ack = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        rf_we;
  logic        retire;
  logic [2:0]  state;
  logic        err;
  logic [31:0] instret;

  core_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .ins          (ins),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .dm_en_in     (dm_en_in),
    .dm_rw_in     (dm_rw_in),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_ack       (dm_ack),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ir           (ir),
    .pc           (pc),
    .rf_we        (rf_we),
    .retire       (retire),
    .state        (state),
    .err          (err),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
    int          rf;
    logic        dm_we;
    logic [2:0]  st;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_instret = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_instret();
`ifdef SEQ_PERF_CNT_EN
    check("instret", instret, model_instret);
`else
    check("instret", instret, 32'h0);
`endif
  endtask

  // Issue one instruction; ack delays count cycles spent waiting in FETCH / MEM.
  task automatic exec_instr(input string tag, input logic [31:0] word, input logic en,
                            input logic rw, input logic tk, input logic [31:0] tgt,
                            input int imem_dly, input int dm_dly, input logic drop_run);
    exp_t e, got;
    logic is_br, done, dmwe_obs;
    int   cyc, fw, mw, rfc;
    is_br = (word[6:0] == 7'b1100011);
    if (is_br) begin
      e.cyc = 3; e.rf = 0; e.pc = tk ? {tgt[31:2], 2'b00} : model_pc + 32'd4;
    end else if (!en) begin
      e.cyc = 4; e.rf = 1; e.pc = model_pc + 32'd4;
    end else if (rw) begin
      e.cyc = 4 + dm_dly; e.rf = 0; e.pc = model_pc + 32'd4;
    end else begin
      e.cyc = 5 + dm_dly; e.rf = 1; e.pc = model_pc + 32'd4;
    end
    e.cyc  += imem_dly;
    e.dm_we = (!is_br && en) ? rw : 1'b0;
    e.st    = drop_run ? S_IDLE : S_FETCH;
    model_pc = e.pc;
    sb.push_back(e);
    ins = word; dm_en_in = en; dm_rw_in = rw; branch_taken = tk; branch_target = tgt;
    cyc = 0; fw = 0; mw = 0; rfc = 0; dmwe_obs = 1'b0; done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      imem_ack = (state == S_FETCH) && (fw >= imem_dly);
      if (state == S_FETCH) fw++;
      dm_ack = (state == S_MEM) && (mw >= dm_dly);
      if (state == S_MEM) mw++;
      if (drop_run && state == S_MEM) run = 1'b0;
      #1;
      if (cyc > 0) cyc++;
      else if (state == S_FETCH) cyc = 1;
      if (rf_we) rfc++;
      if (dm_req) dmwe_obs = dm_we;
      if (state == S_DECODE) check($sformatf("%s_ir", tag), ir, word);
      if (retire) done = 1'b1;
    end
    check($sformatf("%s_retired", tag), 32'(done), 32'd1);
    got = sb.pop_front();
    check($sformatf("%s_cycle", tag), cyc, got.cyc);
    check($sformatf("%s_rf_we", tag), rfc, got.rf);
    check($sformatf("%s_dm_we", tag), 32'(dmwe_obs), 32'(got.dm_we));
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    dm_ack   = 1'b0;
    if (done) model_instret++;
    check($sformatf("%s_pc", tag), pc, got.pc);
    check($sformatf("%s_next_state", tag), 32'(state), 32'(got.st));
  endtask

  initial begin
    int n;
    #3;
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_strobes", {28'h0, imem_req, dm_req, rf_we, retire}, 32'h0);
    check_instret();

    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_hold_state", 32'(state), 32'(S_IDLE));
    check("idle_no_req", 32'(imem_req), 32'd0);
    run = 1'b1;

    exec_instr("add", 32'h0020_8033, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0);
    check("add_addr", imem_addr, 32'h4);
    exec_instr("load_late", 32'h0000_A083, 1'b1, 1'b0, 1'b0, 32'h0, 0, 3, 1'b0);
    exec_instr("store", 32'h0020_A023, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, 1'b0);
    exec_instr("br_taken", 32'h0000_0063, 1'b0, 1'b0, 1'b1, 32'h103, 0, 0, 1'b0);
    exec_instr("br_not_taken", 32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'h200, 0, 0, 1'b0);
    exec_instr("add_slow_fetch", 32'h0041_0133, 1'b0, 1'b0, 1'b0, 32'h0, 2, 0, 1'b0);
    exec_instr("br_top", 32'h0000_0063, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b0);
    exec_instr("load_wrap_drop", 32'h0000_A083, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1, 1'b1);
    check_instret();
    repeat (3) @(negedge clk);
    #1;
    check("dropped_run_idle", 32'(state), 32'(S_IDLE));
    check("dropped_run_no_req", 32'(imem_req), 32'd0);

    // Reset while a fetch is outstanding; a late ack must not load ir.
    run = 1'b1;
    @(negedge clk);
    #1;
    check("midfetch_req", 32'(imem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midfetch_rst_req", 32'(imem_req), 32'd0);
    check("midfetch_rst_state", 32'(state), 32'(S_IDLE));
    check("midfetch_rst_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    imem_ack = 1'b1;
    ins = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    check("late_ack_state", 32'(state), 32'(S_IDLE));
    check("late_ack_ir", ir, 32'h0);
    imem_ack = 1'b0;
    model_instret = 32'h0;
    check_instret();

    // Fetch timeout: sixteen ack-less cycles in FETCH, then ERR.
    run = 1'b1;
    n = 0;
    for (int k = 0; k < 10 && n == 0; k++) begin
      @(negedge clk);
      #1;
      if (state == S_FETCH) n = 1;
    end
    check("tmo_reached_fetch", 32'(n), 32'd1);
    repeat (15) @(negedge clk);
    #1;
    check("tmo_fetch16_state", 32'(state), 32'(S_FETCH));
    @(negedge clk);
    #1;
    check("tmo_err_state", 32'(state), 32'(S_ERR));
    check("tmo_err_flag", 32'(err), 32'd1);
    check("tmo_err_req", {30'h0, imem_req, dm_req}, 32'h0);
    imem_ack = 1'b1;
    dm_ack   = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("err_terminal_state", 32'(state), 32'(S_ERR));
    check("err_terminal_flag", 32'(err), 32'd1);
    check("err_strobes", {28'h0, imem_req, dm_req, rf_we, retire}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("err_rst_state", 32'(state), 32'(S_IDLE));
    check("err_rst_flag", 32'(err), 32'd0);
    imem_ack = 1'b0;
    dm_ack   = 1'b0;
    run      = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter MEM_TIMEOUT, 16, cycles a memory request may wait for ack before error.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  level; permits instruction sequencing.
REQ-006 ins  input  32  instruction word from instruction memory.
REQ-007 imem_req  output  1  fetch request; imem_addr  output  32  fetch address (= pc); imem_ack  input  1  fetch complete, ins valid.
REQ-008 dm_en_in, dm_rw_in  input  1 each  decoder memory-access enable / write (1=store).
REQ-009 dm_req  output  1  data request; dm_we  output  1  write strobe; dm_ack  input  1  data access complete.
REQ-010 branch_taken  input  1; branch_target  input  32  branch outcome and target from datapath.
REQ-011 ir  output  32  instruction register; pc  output  32  program counter.
REQ-012 rf_we  output  1  register-file write pulse; retire  output  1  one-cycle pulse per completed instruction.
REQ-013 state  output  3  current FSM encoding; err  output  1  sticky timeout error.

Function
REQ-014 FSM SHALL have states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
REQ-015 IDLE->FETCH when run=1; else hold.
REQ-016 FETCH: imem_req=1 held until imem_ack; on ack ir<=ins, ->DECODE; ack in same cycle as request entry is accepted; ack while imem_req=0 ignored.
REQ-017 DECODE SHALL last exactly one cycle, ->EXEC.
REQ-018 EXEC (one cycle): ir[6:0]=1100011 (branch) -> retire, ->FETCH/IDLE; dm_en_in=1 -> MEM; otherwise -> WB; dm_rw_in and branch_taken/branch_target sampled here.
REQ-019 MEM: dm_req=1, dm_we=sampled dm_rw_in, held until dm_ack; store -> retire, ->FETCH/IDLE; load -> WB.
REQ-020 WB: rf_we=1 for exactly one cycle, retire=1, ->FETCH/IDLE.
REQ-021 On retire, pc <= taken branch ? {branch_target[31:2],2'b00} : pc+4, modulo 2^32 (0xFFFF_FFFC+4 = 0).
REQ-022 Next state after retire SHALL be FETCH if run=1, else IDLE; run deassertion mid-instruction SHALL NOT abort it.
REQ-023 Latency with zero-wait acks: ALU op 4 cycles, load 5, store 4, branch 3 (FETCH through retire).
REQ-024 Timeout counter SHALL count cycles in FETCH/MEM with ack low, clear on state change; at MEM_TIMEOUT -> ERR, err=1.
REQ-025 ERR SHALL be terminal until rst; all requests and strobes 0 in ERR.
REQ-026 dm_req, imem_req, rf_we, retire SHALL be 0 in every state not listed for them.

Reset
REQ-027 On rst: state=IDLE, pc=RESET_PC, ir=0, err=0, timeout count=0, all request/strobe outputs 0, immediately and asynchronously.
REQ-028 Reset mid-transaction SHALL drop imem_req/dm_req in the same cycle; a later ack SHALL be ignored.

Configuration
REQ-029 Macro SEQ_PERF_CNT_EN: defined -> 32-bit output instret increments on each retire, wraps at 2^32, reset 0; undefined -> instret tied to 0, no counter logic.

Structure
REQ-030 Shared package rv32i_pkg SHALL hold state encodings and opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011, OP 0110011, OP_IMM 0010011).
REQ-031 Timeout counter SHALL be sub-module seq_timeout_ctr (inputs clk, rst, count_en, clear; output expired).

Verification
REQ-032 rst released, run=1, ins=0x00208033 (add), acks immediate -> retire cycle 4, rf_we one pulse, pc=0x4.
REQ-033 load, dm_en_in=1, dm_rw_in=0, dm_ack 3 cycles late -> dm_we=0, WB after ack, retire at cycle 8.
REQ-034 branch ins[6:0]=1100011, branch_taken=1, target=0x103 -> pc=0x100, no rf_we, retire cycle 3.
REQ-035 imem_ack withheld 16 cycles -> state=6, err=1, imem_req=0, stays until rst.
REQ-036 run dropped during MEM -> instruction retires, state=IDLE, no new imem_req; pc=0xFFFF_FFFC non-branch retire -> pc=0.
